// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encodings,
// result-mux select values and the default hang timeout.
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MULT_RUN  = 3'd1,
    DIV_RUN   = 3'd2,
    WRITEBACK = 3'd3,
    EXCEPT    = 3'd4
  } state_e;

  localparam logic SEL_DIV  = 1'b0;
  localparam logic SEL_MULT = 1'b1;

  localparam int DEF_TIMEOUT_CYCLES = 40;

endpackage

// File: rtl/muldiv_sequencer.sv
// Control sequencer for the multicycle mult/div units: launches a unit,
// waits for its stop (or a timeout), then loads HI/LO or reports an exception.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_req,
  input  logic             div_req,
  input  logic             DivZero,
  input  logic             MultStop,
  input  logic             DivStop,
  output logic             MultInit,
  output logic             DivInit,
  output logic             mux_high_low_selector,
  output logic             High_Load,
  output logic             Low_Load,
  output logic             busy,
  output logic             done,
  output logic             div_zero_exc,
  output logic             timeout_err,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT_CYCLES);

  state_e           state;
  logic [CNT_W-1:0] cnt_inc;
  logic             stop_seen;

  // The Init cycle is the first RUN cycle; a stop seen then belongs to the
  // previous operation and is discarded.
  always_comb begin
    cnt_inc   = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);
    stop_seen = 1'b0;
    if (!(MultInit || DivInit)) begin
      if (state == MULT_RUN) stop_seen = MultStop;
      if (state == DIV_RUN)  stop_seen = DivStop;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      MultInit              <= 1'b0;
      DivInit               <= 1'b0;
      mux_high_low_selector <= 1'b0;
      High_Load             <= 1'b0;
      Low_Load              <= 1'b0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      div_zero_exc          <= 1'b0;
      timeout_err           <= 1'b0;
      cycle_count           <= '0;
    end else begin
      MultInit     <= 1'b0;
      DivInit      <= 1'b0;
      High_Load    <= 1'b0;
      Low_Load     <= 1'b0;
      done         <= 1'b0;
      div_zero_exc <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (mult_req) begin
            state                 <= MULT_RUN;
            MultInit              <= 1'b1;
            mux_high_low_selector <= SEL_MULT;
            cycle_count           <= '0;
            busy                  <= 1'b1;
          end else if (div_req && DivZero) begin
            state        <= EXCEPT;
            div_zero_exc <= 1'b1;
            busy         <= 1'b1;
          end else if (div_req) begin
            state                 <= DIV_RUN;
            DivInit               <= 1'b1;
            mux_high_low_selector <= SEL_DIV;
            cycle_count           <= '0;
            busy                  <= 1'b1;
          end
        end
        MULT_RUN, DIV_RUN: begin
          cycle_count <= cnt_inc;
          // A stop landing on the timeout cycle still completes normally.
          if (stop_seen) begin
            state     <= WRITEBACK;
            High_Load <= 1'b1;
            Low_Load  <= 1'b1;
            done      <= 1'b1;
          end else if (cnt_inc == TO_CNT) begin
            state       <= EXCEPT;
            timeout_err <= 1'b1;
          end
        end
        WRITEBACK, EXCEPT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
